// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the program counter and issues one word address per cycle to a
// synchronous-read instruction memory with one cycle of latency. Each returned
// word is tagged with the PC that produced it and goes into a 2-entry queue
// that feeds decode over a valid/ready handshake.
//
// Ports
//   i_Clk, i_Rst         clock, asynchronous active-low reset
//   o_ImemAddr[29:0]     word address to instruction memory
//   i_ImemInst[31:0]     memory read data for the previous cycle's address
//   o_Valid/o_Inst/o_Pc  queue head (instruction and its byte PC)
//   i_Ready              decode accepts the head this cycle
//   i_Redirect/_Pc       one-cycle flush and restart at a new PC
//   i_Halt               stop issuing; queued entries still drain
//   o_FetchCnt[31:0]     number of instructions delivered (wraps)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic [29:0] o_ImemAddr,
  input  logic [31:0] i_ImemInst,
  output logic        o_Valid,
  output logic [31:0] o_Inst,
  output logic [31:0] o_Pc,
  input  logic        i_Ready,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPc,
  input  logic        i_Halt,
  output logic [31:0] o_FetchCnt
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  fq_entry_t [1:0] fq;
  logic            fq_head;
  logic [1:0]      fq_cnt;
  logic [31:0]     pc_q;
  logic            iss_vld;
  logic [31:0]     iss_pc;
  logic [31:0]     fetch_cnt;

  logic [31:0] tgt_pc;
  logic [31:0] issue_pc;
  logic [1:0]  occ;
  logic        pop;
  logic        push;
  logic        issue;
  logic        tail;

  always_comb begin
    tgt_pc   = {i_RedirectPc[31:2], 2'b00};
    issue_pc = i_Redirect ? tgt_pc : pc_q;
    // A redirect discards both the queue and the in-flight return.
    pop      = (fq_cnt != 2'd0) && i_Ready && !i_Redirect;
    push     = iss_vld && !i_Redirect;
    // Credit: queued entries plus the word returning next edge. Never above 2.
    occ      = fq_cnt + {1'b0, iss_vld};
    if (i_Redirect)
      issue = !i_Halt;                 // queue flushed, credit always exists
    else
      issue = !i_Halt && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    // Next free slot; with count 0 it is the head, with count 1 the other one.
    tail     = fq_head ^ fq_cnt[0];
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      fq        <= '0;
      fq_head   <= 1'b0;
      fq_cnt    <= 2'd0;
      pc_q      <= RESET_PC;
      iss_vld   <= 1'b0;
      iss_pc    <= 32'd0;
      fetch_cnt <= 32'd0;
    end else begin
      iss_vld <= issue;
      if (issue) begin
        iss_pc <= issue_pc;
        pc_q   <= issue_pc + 32'd4;
      end else if (i_Redirect) begin
        pc_q   <= tgt_pc;              // halted redirect: resume here later
      end

      if (i_Redirect) begin
        fq_cnt <= 2'd0;
      end else begin
        if (push) begin
          fq[tail].inst <= i_ImemInst;
          fq[tail].pc   <= iss_pc;
        end
        if (pop) begin
          fq_head   <= ~fq_head;
          fetch_cnt <= fetch_cnt + 32'd1;
        end
        case ({push, pop})
          2'b10:   fq_cnt <= fq_cnt + 2'd1;
          2'b01:   fq_cnt <= fq_cnt - 2'd1;
          default: fq_cnt <= fq_cnt;
        endcase
      end
    end
  end

  assign o_ImemAddr = issue_pc[31:2];
  assign o_Valid    = (fq_cnt != 2'd0);
  assign o_Inst     = fq[fq_head].inst;
  assign o_Pc       = fq[fq_head].pc;
  assign o_FetchCnt = fetch_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl against a queue-level model
// of the fetch stream, plus directed checks on latency, stall, redirect,
// halt, PC wrap and mid-stream reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] imem_addr;
  logic [31:0] imem_inst;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .o_ImemAddr  (imem_addr),
    .i_ImemInst  (imem_inst),
    .o_Valid     (valid),
    .o_Inst      (inst),
    .o_Pc        (pc),
    .i_Ready     (ready),
    .i_Redirect  (redirect),
    .i_RedirectPc(redirect_pc),
    .i_Halt      (halt),
    .o_FetchCnt  (fetch_cnt)
  );

  // Memory image: a few fixed words, the rest an injective scramble of the address.
  function automatic logic [31:0] word(input logic [29:0] a);
    case (a)
      30'd0:   word = 32'h0000_0000;
      30'd1:   word = 32'h0050_0513;
      30'd2:   word = 32'h00a5_8633;
      30'd19:  word = 32'h00c6_8263;
      default: word = {a[13:0], 2'b11, a[29:14]} ^ 32'h1357_9bdf;
    endcase
  endfunction

  always @(posedge clk) imem_inst <= word(imem_addr);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference model: ordered stream of fetched words.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_iss;
  logic [31:0] m_iss_pc;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  logic        obs_valid;
  logic [31:0] obs_pc, obs_inst, obs_cnt;
  logic [29:0] obs_addr;

  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic h, input logic rdy);
    logic        do_pop, do_iss;
    logic [31:0] tgt;
    int          occ;
    ent_t        e;
    @(negedge clk);
    obs_valid = valid;
    obs_pc    = pc;
    obs_inst  = inst;
    obs_cnt   = fetch_cnt;
    chk("valid", {31'd0, valid}, {31'd0, (mq.size() != 0)});
    if (mq.size() != 0) begin
      chk("pc", pc, mq[0].pc);
      chk("inst", inst, mq[0].inst);
    end
    chk("fetch_cnt", fetch_cnt, m_cnt);
    redirect    = rd;
    redirect_pc = rpc;
    halt        = h;
    ready       = rdy;
    #1;
    obs_addr = imem_addr;
    chk("imem_addr", {2'b00, imem_addr}, rd ? {2'b00, rpc[31:2]} : {2'b00, m_pc[31:2]});
    @(posedge clk);
    if (rd) begin
      tgt = {rpc[31:2], 2'b00};
      mq.delete();
      if (!h) begin
        m_iss = 1'b1; m_iss_pc = tgt; m_pc = tgt + 32'd4;
      end else begin
        m_iss = 1'b0; m_pc = tgt;
      end
    end else begin
      do_pop = (mq.size() != 0) && rdy;
      occ    = mq.size() + int'(m_iss);
      do_iss = !h && ((occ < 2) || (occ == 2 && do_pop));
      if (do_pop) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (m_iss) begin
        e.pc = m_iss_pc; e.inst = word(m_iss_pc[31:2]);
        mq.push_back(e);
      end
      if (do_iss) begin
        m_iss = 1'b1; m_iss_pc = m_pc; m_pc = m_pc + 32'd4;
      end else begin
        m_iss = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect = 1'b0; halt = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_addr", {2'b00, imem_addr}, 32'd0);
    mq.delete(); m_iss = 1'b0; m_iss_pc = 32'd0; m_pc = 32'd0; m_cnt = 32'd0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [31:0] c0, last_pc;
    logic [29:0] a0;
    logic        h;
    logic        rd, rdy;
    logic [31:0] rpc;
    rst = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
    do_reset();

    // First fetches after reset.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      if (i < 2) chk("lat_valid", {31'd0, obs_valid}, 32'd0);
      if (i == 2) begin
        chk("f0_valid", {31'd0, obs_valid}, 32'd1);
        chk("f0_pc", obs_pc, 32'h0); chk("f0_inst", obs_inst, 32'h0000_0000);
      end
      if (i == 3) begin chk("f1_pc", obs_pc, 32'h4); chk("f1_inst", obs_inst, 32'h0050_0513); end
      if (i == 4) begin chk("f2_pc", obs_pc, 32'h8); chk("f2_inst", obs_inst, 32'h00a5_8633); end
      if (i == 5) chk("f_cnt3", obs_cnt, 32'd3);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Ready low for 5 cycles: counter frozen, issue address held.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b0);
      if (k == 0) begin c0 = obs_cnt; a0 = obs_addr; end
      else begin
        chk("stall_cnt", obs_cnt, c0);
        chk("stall_addr", {2'b00, obs_addr}, {2'b00, a0});
        chk("stall_valid", {31'd0, obs_valid}, 32'd1);
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Redirect with the queue full.
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_004c, 1'b0, 1'b1);
    c0 = obs_cnt;
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("rd_gap", {31'd0, obs_valid}, 32'd0);
    chk("rd_cnt", obs_cnt, c0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("rd_valid", {31'd0, obs_valid}, 32'd1);
    chk("rd_pc", obs_pc, 32'h0000_004c);
    chk("rd_inst", obs_inst, 32'h00c6_8263);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("rd_next_pc", obs_pc, 32'h0000_0050);

    // Halt 4 cycles with ready high: drains, then resumes sequentially.
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      if (k == 1) last_pc = obs_pc;
      if (k >= 2) chk("halt_drained", {31'd0, obs_valid}, 32'd0);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("halt_gap", {31'd0, obs_valid}, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("halt_resume_pc", obs_pc, last_pc + 32'd4);

    // PC wrap and misaligned target.
    cycle(1'b1, 32'hffff_fffc, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("wrap_pc0", obs_pc, 32'hffff_fffc);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("wrap_pc1", obs_pc, 32'h0000_0000);
    cycle(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("align_pc", obs_pc, 32'h0000_0100);

    // Reset mid-stream with the queue full.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      if (i == 1) chk("rerst_gap", {31'd0, obs_valid}, 32'd0);
    end
    chk("rerst_valid", {31'd0, obs_valid}, 32'd1);
    chk("rerst_pc", obs_pc, 32'h0);

    // Randomized traffic.
    h = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rd  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 9) == 0) h = ~h;
      rdy = ($urandom_range(0, 9) < 7);
      cycle(rd, rpc, h, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
